std_cache_bypass_arbiter: RTL and testbench
===========================================

Name: std_cache_bypass_arbiter

Overview:
- Shares the single uncached/bypass port of the standard data cache between NUM_PORTS requesters (load unit, store unit, AMO, miss handler).
- Requester-side fields match bypass_req_t / bypass_rsp_t: req, reqtype, acetype, amo, id, addr, wdata, we, be, size; gnt, valid, rdata.
- Round-robin arbitration with exactly one transaction outstanding downstream.
- The downstream request is registered; grant and response return paths are combinational pass-through to the owning port.

Parameters:
- NUM_PORTS, 3, number of requesters (2..8).
- PTR_W, $clog2(NUM_PORTS), width of the port index.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_ports_i  in  NUM_PORTS x bypass_req_t  per-port requests.
- rsp_ports_o  out  NUM_PORTS x bypass_rsp_t  per-port gnt/valid/rdata.
- bypass_req_o  out  bypass_req_t  registered downstream request.
- bypass_rsp_i  in  bypass_rsp_t  downstream gnt/valid/rdata.
- busy_o  out  1  high whenever state != IDLE.
- timeout_o  out  1  one-cycle watchdog pulse (0 when the feature is off).

Behaviour:
- Reset is synchronous, active-high, on the clk_i edge. Reset values:
  - state = IDLE, rr_ptr = NUM_PORTS-1, owner = 0.
  - bypass_req_o = '0; all rsp_ports_o gnt/valid = 0, rdata = 0.
  - busy_o = 0, timeout_o = 0.
- Reset mid-transaction drops the transaction silently: no gnt or valid is issued afterwards.
- States:
  - IDLE: if any req_ports_i[k].req, select the first requesting k in round-robin order starting at rr_ptr+1, wrapping modulo NUM_PORTS. Latch req_ports_i[k] into bypass_req_o with req=1 and force id to {latched id}. Set owner=k, rr_ptr=k, go to REQ. No gnt is returned in IDLE.
  - REQ: hold bypass_req_o stable. When bypass_rsp_i.gnt, drive rsp_ports_o[owner].gnt=1 in the same cycle and clear bypass_req_o.req next cycle.
    - If valid arrives in the same cycle as gnt: also drive rsp_ports_o[owner].valid=1 with rdata, then go to IDLE.
    - Otherwise go to WAIT.
  - WAIT: when bypass_rsp_i.valid, drive rsp_ports_o[owner].valid=1 and rdata=bypass_rsp_i.rdata in the same cycle, then go to IDLE.
- Minimum latency: request seen at cycle 0 → bypass_req_o.req=1 at cycle 1 → earliest gnt_o at cycle 1 → earliest valid_o at cycle 1. The earliest new arbitration is the cycle after valid.
- Non-owner ports always see gnt=valid=0; rdata is 0 for non-owners.
- A requester holds req and its fields until it sees gnt. A request withdrawn before gnt is illegal; the arbiter does not track it, since fields are latched at arbitration.
- Responses (valid_i) arriving in IDLE are ignored.
- Grant (gnt_i) is ignored in WAIT.
- A single requester requesting back-to-back is served every transaction; there is no starvation under round-robin.

Optional Feature:
- Macro: STD_CACHE_BYPASS_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - On reaching TIMEOUT_CYCLES-1 without completion: pulse timeout_o for one cycle, drive rsp_ports_o[owner].valid=1 with rdata='1, go to IDLE.
  - A downstream gnt or valid arriving later is ignored until the next REQ.
- When undefined: no counter is present, timeout_o is tied to 0, and the arbiter waits indefinitely.

Test Plan:
- Single request: port1 req addr=0x8000_0010, gnt_i on cycle 2, valid_i rdata=0xDEAD_BEEF on cycle 4 → bypass_req_o.addr=0x8000_0010 from cycle 1; port1 gnt=1 at cycle 2, valid=1 with rdata=0xDEAD_BEEF at cycle 4; busy_o low at cycle 5.
- Round-robin: ports 0, 1, 2 request continuously, downstream gnt and valid one cycle after req → owner order 0, 1, 2, 0; each port receives gnt exactly once per round.
- Simultaneous gnt and valid in REQ → owner receives gnt and valid in the same cycle; state returns to IDLE next cycle; no WAIT cycle.
- Reset mid-WAIT: rst_i=1 for one cycle, then valid_i=1 → no rsp valid on any port; bypass_req_o.req=0; rr_ptr back to NUM_PORTS-1 so port0 wins next.
- Isolation: port2 owns the transaction while port0 requests → port0 sees gnt=0, valid=0, rdata=0 until its own turn.
- With STD_CACHE_BYPASS_TIMEOUT_EN and TIMEOUT_CYCLES=8, no gnt_i ever → timeout_o pulse 8 cycles after entering REQ; owner valid=1 with rdata=all-ones; a late gnt_i is ignored.

Source files
------------

// File: rtl/std_cache_bypass_arbiter_if.sv
// Requester-side and downstream bypass-port bundle for std_cache_bypass_arbiter.
// The arbiter uses the slave modport; requesters and the downstream port use master.
interface std_cache_bypass_arbiter_if #(
  parameter int NUM_PORTS = 3
);
  typedef struct packed {
    logic        req;
    logic        reqtype;
    logic [3:0]  acetype;
    logic [3:0]  amo;
    logic [3:0]  id;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        we;
    logic [7:0]  be;
    logic [1:0]  size;
  } bypass_req_t;

  typedef struct packed {
    logic        gnt;
    logic        valid;
    logic [63:0] rdata;
  } bypass_rsp_t;

  bypass_req_t req_ports_i [NUM_PORTS];
  bypass_rsp_t rsp_ports_o [NUM_PORTS];
  bypass_req_t bypass_req_o;
  bypass_rsp_t bypass_rsp_i;

  modport slave  (input  req_ports_i, bypass_rsp_i, output rsp_ports_o, bypass_req_o);
  modport master (output req_ports_i, bypass_rsp_i, input  rsp_ports_o, bypass_req_o);
endinterface

// File: rtl/std_cache_bypass_arbiter.sv
// Round-robin arbiter sharing the data-cache bypass port, one transaction in flight.
// Optional watchdog enabled by defining STD_CACHE_BYPASS_TIMEOUT_EN.
module std_cache_bypass_arbiter #(
  parameter int NUM_PORTS      = 3,
  parameter int PTR_W          = $clog2(NUM_PORTS),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  std_cache_bypass_arbiter_if.slave        bus,
  output logic                             busy_o,
  output logic                             timeout_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e           r_state, w_state_nxt;
  logic [PTR_W-1:0] r_rr_ptr, r_owner, w_sel;
  logic             w_any, w_done, w_timeout;

  // First requester strictly after the last winner, wrapping modulo NUM_PORTS.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!w_any && bus.req_ports_i[(int'(r_rr_ptr) + i) % NUM_PORTS].req) begin
        w_any = 1'b1;
        w_sel = PTR_W'((int'(r_rr_ptr) + i) % NUM_PORTS);
      end
    end
  end

  assign w_done = ((r_state == REQ) && bus.bypass_rsp_i.gnt && bus.bypass_rsp_i.valid) ||
                  ((r_state == WAIT) && bus.bypass_rsp_i.valid);

`ifdef STD_CACHE_BYPASS_TIMEOUT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || r_state == IDLE) r_cnt <= '0;
    else                          r_cnt <= r_cnt + 16'd1;
  end

  assign w_timeout = (r_state != IDLE) && !w_done && (r_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    for (int p = 0; p < NUM_PORTS; p++) bus.rsp_ports_o[p] = '0;
    case (r_state)
      IDLE: if (w_any) w_state_nxt = REQ;
      REQ: begin
        if (bus.bypass_rsp_i.gnt) begin
          bus.rsp_ports_o[r_owner].gnt = 1'b1;
          if (bus.bypass_rsp_i.valid) begin
            bus.rsp_ports_o[r_owner].valid = 1'b1;
            bus.rsp_ports_o[r_owner].rdata = bus.bypass_rsp_i.rdata;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.bypass_rsp_i.valid) begin
          bus.rsp_ports_o[r_owner].valid = 1'b1;
          bus.rsp_ports_o[r_owner].rdata = bus.bypass_rsp_i.rdata;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Watchdog completes the owner with an all-ones error response.
    if (w_timeout) begin
      bus.rsp_ports_o[r_owner].valid = 1'b1;
      bus.rsp_ports_o[r_owner].rdata = '1;
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state          <= IDLE;
      r_rr_ptr         <= PTR_W'(NUM_PORTS - 1);
      r_owner          <= '0;
      bus.bypass_req_o <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_any) begin
        bus.bypass_req_o     <= bus.req_ports_i[w_sel];
        bus.bypass_req_o.req <= 1'b1;
        r_owner              <= w_sel;
        r_rr_ptr             <= w_sel;
      end else if (r_state == REQ && (bus.bypass_rsp_i.gnt || w_timeout)) begin
        bus.bypass_req_o.req <= 1'b0;
      end
    end
  end

  assign busy_o    = (r_state != IDLE);
  assign timeout_o = w_timeout;
endmodule

// File: tb/tb_std_cache_bypass_arbiter.sv
// Directed bench for std_cache_bypass_arbiter: single request, round-robin order,
// same-cycle gnt/valid, owner isolation, reset mid-transaction and the watchdog.
module tb_std_cache_bypass_arbiter;
  localparam int NP = 3;

  logic clk = 1'b0;
  logic rst;
  logic busy, tmo;
  int   tests  = 0;
  int   failed = 0;
  int   order [4] = '{0, 1, 2, 0};
  int   n;

  always #5 clk = ~clk;

  std_cache_bypass_arbiter_if #(.NUM_PORTS(NP)) bus ();

  std_cache_bypass_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(8)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus),
    .busy_o   (busy),
    .timeout_o(tmo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, {63'd0, obs}, {63'd0, exp});
  endtask

  task automatic chk_port(input string tag, input int p, input logic g, input logic v,
                          input logic [63:0] d);
    chkb({tag, ".gnt"},   bus.rsp_ports_o[p].gnt,   g);
    chkb({tag, ".valid"}, bus.rsp_ports_o[p].valid, v);
    chk ({tag, ".rdata"}, bus.rsp_ports_o[p].rdata, d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int p = 0; p < NP; p++) bus.req_ports_i[p] = '0;
    bus.bypass_rsp_i = '0;
    tick();
    tick();
    chkb("rst.busy", busy, 1'b0);
    chkb("rst.timeout", tmo, 1'b0);
    chk("rst.bypass_req", bus.bypass_req_o, 64'd0);
    for (int p = 0; p < NP; p++) chk_port($sformatf("rst.p%0d", p), p, 1'b0, 1'b0, 64'd0);

    // Stray response and grant while idle must not reach any port.
    rst = 1'b0;
    tick();
    bus.bypass_rsp_i = '{gnt: 1'b1, valid: 1'b1, rdata: 64'hABC};
    settle();
    for (int p = 0; p < NP; p++) chk_port($sformatf("idle_stray.p%0d", p), p, 1'b0, 1'b0, 64'd0);
    bus.bypass_rsp_i = '0;

    // Single request from port 1.
    bus.req_ports_i[1].req  = 1'b1;
    bus.req_ports_i[1].addr = 64'h8000_0010;
    bus.req_ports_i[1].id   = 4'd5;
    settle();
    chk_port("single.c0", 1, 1'b0, 1'b0, 64'd0);
    tick();
    chkb("single.c1.req", bus.bypass_req_o.req, 1'b1);
    chk("single.c1.addr", bus.bypass_req_o.addr, 64'h8000_0010);
    chk("single.c1.id", {60'd0, bus.bypass_req_o.id}, 64'd5);
    chkb("single.c1.busy", busy, 1'b1);
    chk_port("single.c1", 1, 1'b0, 1'b0, 64'd0);
    tick();
    bus.bypass_rsp_i.gnt = 1'b1;
    settle();
    chk_port("single.c2.p1", 1, 1'b1, 1'b0, 64'd0);
    chk_port("single.c2.p0", 0, 1'b0, 1'b0, 64'd0);
    tick();
    bus.req_ports_i[1].req = 1'b0;
    settle();
    chkb("single.c3.req_cleared", bus.bypass_req_o.req, 1'b0);
    chk_port("single.c3.wait_gnt_ignored", 1, 1'b0, 1'b0, 64'd0);
    chkb("single.c3.busy", busy, 1'b1);
    bus.bypass_rsp_i.gnt = 1'b0;
    tick();
    bus.bypass_rsp_i = '{gnt: 1'b0, valid: 1'b1, rdata: 64'hDEAD_BEEF};
    settle();
    chk_port("single.c4.p1", 1, 1'b0, 1'b1, 64'hDEAD_BEEF);
    chk_port("single.c4.p0", 0, 1'b0, 1'b0, 64'd0);
    chk_port("single.c4.p2", 2, 1'b0, 1'b0, 64'd0);
    tick();
    bus.bypass_rsp_i = '0;
    settle();
    chkb("single.c5.busy", busy, 1'b0);

    // Round-robin with all three ports requesting continuously.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int p = 0; p < NP; p++) begin
      bus.req_ports_i[p].req  = 1'b1;
      bus.req_ports_i[p].addr = 64'h1000 + 64'(p) * 64'h100;
      bus.req_ports_i[p].id   = 4'(p);
    end
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("rr%0d.addr", t), bus.bypass_req_o.addr, 64'h1000 + 64'(order[t]) * 64'h100);
      bus.bypass_rsp_i.gnt = 1'b1;
      settle();
      for (int p = 0; p < NP; p++)
        chkb($sformatf("rr%0d.gnt.p%0d", t, p), bus.rsp_ports_o[p].gnt, p == order[t]);
      tick();
      bus.bypass_rsp_i = '{gnt: 1'b0, valid: 1'b1, rdata: 64'hA0 + 64'(t)};
      settle();
      chk_port($sformatf("rr%0d.rsp", t), order[t], 1'b0, 1'b1, 64'hA0 + 64'(t));
      tick();
      bus.bypass_rsp_i = '0;
      settle();
      chkb($sformatf("rr%0d.idle", t), busy, 1'b0);
    end

    // Same-cycle gnt and valid: port 1 is next, no WAIT cycle follows.
    tick();
    chk("both.addr", bus.bypass_req_o.addr, 64'h1100);
    bus.bypass_rsp_i = '{gnt: 1'b1, valid: 1'b1, rdata: 64'h1234};
    settle();
    chk_port("both.p1", 1, 1'b1, 1'b1, 64'h1234);
    chk_port("both.p0", 0, 1'b0, 1'b0, 64'd0);
    bus.req_ports_i[1].req = 1'b0;
    tick();
    bus.bypass_rsp_i = '0;
    settle();
    chkb("both.no_wait", busy, 1'b0);

    // Isolation: port 2 owns while port 0 keeps requesting.
    tick();
    chk("iso.addr", bus.bypass_req_o.addr, 64'h1200);
    chk_port("iso.req.p0", 0, 1'b0, 1'b0, 64'd0);
    bus.bypass_rsp_i.gnt = 1'b1;
    settle();
    chk_port("iso.gnt.p0", 0, 1'b0, 1'b0, 64'd0);
    chk_port("iso.gnt.p2", 2, 1'b1, 1'b0, 64'd0);
    bus.req_ports_i[2].req = 1'b0;
    tick();
    bus.bypass_rsp_i = '{gnt: 1'b0, valid: 1'b1, rdata: 64'hCAFE};
    settle();
    chk_port("iso.valid.p0", 0, 1'b0, 1'b0, 64'd0);
    chk_port("iso.valid.p2", 2, 1'b0, 1'b1, 64'hCAFE);
    tick();
    bus.bypass_rsp_i = '0;
    tick();
    chk("iso.own_turn.addr", bus.bypass_req_o.addr, 64'h1000);

    // Reset while port 0 waits for its response.
    bus.bypass_rsp_i.gnt = 1'b1;
    settle();
    chk_port("rstw.gnt.p0", 0, 1'b1, 1'b0, 64'd0);
    bus.req_ports_i[0].req = 1'b0;
    tick();
    bus.bypass_rsp_i.gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.bypass_rsp_i = '{gnt: 1'b0, valid: 1'b1, rdata: 64'h5555};
    bus.req_ports_i[0].req = 1'b1;
    bus.req_ports_i[1].req = 1'b1;
    settle();
    for (int p = 0; p < NP; p++) chk_port($sformatf("rstw.p%0d", p), p, 1'b0, 1'b0, 64'd0);
    chkb("rstw.req", bus.bypass_req_o.req, 1'b0);
    chkb("rstw.busy", busy, 1'b0);
    tick();
    bus.bypass_rsp_i = '0;
    settle();
    chk("rstw.port0_wins", bus.bypass_req_o.addr, 64'h1000);
    chk_port("rstw.after.p0", 0, 1'b0, 1'b0, 64'd0);
    bus.bypass_rsp_i = '{gnt: 1'b1, valid: 1'b1, rdata: 64'h77};
    settle();
    chk_port("rstw.done.p0", 0, 1'b1, 1'b1, 64'h77);
    bus.req_ports_i[0].req = 1'b0;
    bus.req_ports_i[1].req = 1'b0;
    tick();
    bus.bypass_rsp_i = '0;
    settle();
    chkb("rstw.idle", busy, 1'b0);

    // Downstream never grants.
    bus.req_ports_i[2].req  = 1'b1;
    bus.req_ports_i[2].addr = 64'h2000;
`ifdef STD_CACHE_BYPASS_TIMEOUT_EN
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (tmo && n == 0) n = c;
      if (n != 0) break;
    end
    chk("tmo.cycle", 64'(n), 64'd8);
    chk_port("tmo.p2", 2, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.req_ports_i[2].req = 1'b0;
    tick();
    bus.bypass_rsp_i.gnt = 1'b1;
    settle();
    chkb("tmo.pulse_once", tmo, 1'b0);
    chkb("tmo.idle", busy, 1'b0);
    chk_port("tmo.late_gnt", 2, 1'b0, 1'b0, 64'd0);
    bus.bypass_rsp_i = '0;
`else
    n = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (tmo) n++;
    end
    chk("stall.timeout_pulses", 64'(n), 64'd0);
    chkb("stall.busy", busy, 1'b1);
    bus.bypass_rsp_i = '{gnt: 1'b1, valid: 1'b1, rdata: 64'h99};
    settle();
    chk_port("stall.done", 2, 1'b1, 1'b1, 64'h99);
    bus.req_ports_i[2].req = 1'b0;
    tick();
    bus.bypass_rsp_i = '0;
    settle();
    chkb("stall.idle", busy, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
